mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: MEM_ADDR_BITS, 14, implemented byte-address width; any set req_addr bit at or above it is out of range.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  load/store request present.
REQ-005 SHALL have port: req_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port: req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port: resp_valid  output  1  response present.
REQ-012 SHALL have port: resp_ready  input  1  consumer takes response.
REQ-013 SHALL have port: resp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 SHALL have port: resp_err  output  1  request rejected, no memory access.
REQ-015 SHALL have port: mem_addr  output  32  word address to memory data port; bits [1:0] always 0.
REQ-016 SHALL have port: mem_wdata  output  32  full-word write data.
REQ-017 SHALL have port: mem_wr_en  output  1  memory write strobe, sampled by memory on rising clk.
REQ-018 SHALL have port: mem_rdata  input  35  combinational read data; only bits [31:0] used, [34:32] ignored.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL capture size, signed, addr, wdata, write on the edge where req_valid & req_ready.
REQ-021 SHALL transition from IDLE on acceptance: error -> RESP; load or sub-word store -> READ; word store -> WRITE.
REQ-022 SHALL treat req_size 11 or out-of-range address as error: resp_err = 1, no READ/WRITE state entered.
REQ-023 SHALL register mem_rdata[31:0] at the end of READ; load -> RESP, sub-word store -> WRITE.
REQ-024 SHALL assert mem_wr_en for exactly one cycle, only in WRITE; then -> RESP.
REQ-025 SHALL form a sub-word store word by replacing only the addressed lane of the READ word: byte lane addr[1:0], half lane addr[1] (bits [15:0] or [31:16]); other bytes unchanged.
REQ-026 SHALL extract loads by lane and zero-extend, or sign-extend when req_signed = 1; word loads return the word unmodified.
REQ-027 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready = 1, then -> IDLE next edge.
REQ-028 SHALL give latencies from acceptance edge to resp_valid high: load 2, word store 2, sub-word store 3, error 1 edges.
REQ-029 SHALL hold mem_addr at captured addr with [1:0] forced to 00 in READ and WRITE, and at 0 otherwise.
REQ-030 SHALL not accept a new request in the RESP cycle where resp_ready is high; earliest accept is the following IDLE cycle.

Reset
REQ-031 SHALL on reset force state IDLE, req_ready = 1 after release, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_wr_en = 0, mem_addr = 0, mem_wdata = 0, all captured registers = 0.
REQ-032 SHALL on reset assertion mid-operation drop mem_wr_en immediately and abandon the request; no response is produced for it.

Configuration
REQ-033 SHALL honor macro MISALIGN_TRAP_EN: defined -> halfword with addr[0] = 1 or word with addr[1:0] != 00 is an error per REQ-022; undefined -> misaligned low bits ignored (halfword uses addr[1], word uses addr[1:0] = 00) and access proceeds.

Verification
REQ-034 SHALL pass: word store 0xDEADBEEF @0x10 then word load @0x10 -> mem_wr_en one cycle, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-035 SHALL pass: memory word @0x20 = 0x11223344, byte store 0xAA @0x21 -> memory word 0x1122AA44, resp_valid 3 edges after accept.
REQ-036 SHALL pass: word 0x0000FF80 @0x30, byte load @0x30 signed -> 0xFFFFFF80; unsigned -> 0x00000080; half load @0x30 signed -> 0xFFFFFF80... halfword @0x30 = 0xFF80 -> 0xFFFFFF80.
REQ-037 SHALL pass: load @0x00004000 (MEM_ADDR_BITS 14) -> resp_err 1, resp_rdata 0, mem_wr_en never asserted, resp_valid 1 edge after accept.
REQ-038 SHALL pass: resp_ready held 0 for 5 cycles -> resp outputs stable, req_ready 0; word load @0x12 -> err with MISALIGN_TRAP_EN, data of @0x10 without.
REQ-039 SHALL pass: reset asserted in WRITE before clk edge -> mem_wr_en 0 immediately, memory word unchanged, state IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port load/store sequencer with sub-word read-modify-write.
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module mem_access_unit #(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  input  logic [34:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        size_err;
  logic        range_err;
  logic        align_err;
  logic        req_err;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merge_val;
  logic        unused;

  // Upper memory read bits carry no data.
  assign unused = ^mem_rdata[34:32];

  assign size_err  = (req_size == 2'b11);
  assign range_err = |(req_addr >> MEM_ADDR_BITS);
`ifdef MISALIGN_TRAP_EN
  assign align_err =
    ((req_size == 2'b01) && req_addr[0]) ||
    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif
  assign req_err = size_err | range_err | align_err;

  always_comb begin
    rd_word  = mem_rdata[31:0];
    byte_sel = rd_word[{addr_q[1:0], 3'b000} +: 8];
    half_sel = rd_word[{addr_q[1], 4'b0000} +: 16];
    load_val = rd_word;
    unique case (1'b1)
      (size_q == 2'b00):
        load_val = {{24{signed_q & byte_sel[7]}},
                    byte_sel};
      (size_q == 2'b01):
        load_val = {{16{signed_q & half_sel[15]}},
                    half_sel};
      default:
        load_val = rd_word;
    endcase
  end

  // Sub-word stores patch only the addressed lane.
  always_comb begin
    merge_val = rd_word;
    unique case (1'b1)
      (size_q == 2'b00):
        merge_val[{addr_q[1:0], 3'b000} +: 8] =
          wdata_q[7:0];
      (size_q == 2'b01):
        merge_val[{addr_q[1], 4'b0000} +: 16] =
          wdata_q[15:0];
      default:
        merge_val = rd_word;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            size_q    <= req_size;
            signed_q  <= req_signed;
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write &&
                         (req_size == 2'b10)) begin
              state     <= WRITE;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_wdata;
              mem_wr_en <= 1'b1;
            end else begin
              state    <= READ;
              mem_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        READ: begin
          if (write_q) begin
            state     <= WRITE;
            mem_wdata <= merge_val;
            mem_wr_en <= 1'b1;
          end else begin
            state      <= RESP;
            mem_addr   <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_val;
          end
        end
        WRITE: begin
          state      <= RESP;
          mem_wr_en  <= 1'b0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Memory model is a 14-bit byte-addressed word array with a preload port.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic [34:0] mem_rdata;

  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_idx = '0;
  logic [31:0] pre_data = '0;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.MEM_ADDR_BITS(14)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {3'b111, mem[mem_addr[13:2]]};

  always @(posedge clk) begin
    if (mem_wr_en)
      mem[mem_addr[13:2]] <= mem_wdata;
    else if (pre_en)
      mem[pre_idx] <= pre_data;
  end

  task automatic poke(input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1;
    pre_idx = a[13:2];
    pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issues one request, leaves the unit in RESP (resp_ready low).
  task automatic xact(input logic w, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int wr,
                      output logic [31:0] wa);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    wr = 0;
    wa = 32'hFFFF_FFFF;
    forever begin
      if (mem_wr_en) begin
        wr++;
        wa = mem_addr;
      end
      if (resp_valid || lat >= 20) break;
      @(posedge clk);
      #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    checks++;
    if (resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp_err got=%b exp=0", resp_err);
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", resp_rdata);
    end
    checks++;
    if (mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem_addr got=%h exp=0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata);
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] rd, wa;
    logic er;
    int lat, wr;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (lat !== 2 || wr !== 1 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL wstore_resp lat=%0d wr=%0d err=%b rd=%h exp lat=2 wr=1 err=0 rd=0",
               lat, wr, er, rd);
    end
    checks++;
    if (wa !== 32'h10) begin
      failures++;
      $display("FAIL wstore_addr got=%h exp=00000010", wa);
    end
    checks++;
    if (mem[4] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wstore_mem got=%h exp=deadbeef", mem[4]);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL wload_data got=%h err=%b exp=deadbeef err=0", rd, er);
    end
    checks++;
    if (lat !== 2 || wr !== 0) begin
      failures++;
      $display("FAIL wload_lat lat=%0d wr=%0d exp lat=2 wr=0", lat, wr);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd, wa;
    logic er;
    int lat, wr;
    poke(32'h20, 32'h1122_3344);
    xact(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAA,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (lat !== 3 || wr !== 1 || er !== 1'b0) begin
      failures++;
      $display("FAIL bstore_lat lat=%0d wr=%0d err=%b exp lat=3 wr=1 err=0",
               lat, wr, er);
    end
    checks++;
    if (mem[8] !== 32'h1122_AA44) begin
      failures++;
      $display("FAIL bstore_mem got=%h exp=1122aa44", mem[8]);
    end
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (mem[8] !== 32'hBEEF_AA44 || lat !== 3) begin
      failures++;
      $display("FAIL hstore_mem got=%h lat=%0d exp=beefaa44 lat=3", mem[8], lat);
    end
    xact(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_0077,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (mem[8] !== 32'h77EF_AA44) begin
      failures++;
      $display("FAIL bstore_lane3 got=%h exp=77efaa44", mem[8]);
    end
  endtask

  task automatic test_loads();
    logic [31:0] rd, wa;
    logic er;
    int lat, wr;
    logic [31:0] exp_v [0:6];
    logic [31:0] addr_v [0:6];
    logic [1:0]  size_v [0:6];
    logic        sgn_v [0:6];
    addr_v = '{32'h30, 32'h30, 32'h30, 32'h30,
               32'h31, 32'h32, 32'h36};
    size_v = '{2'b00, 2'b00, 2'b01, 2'b01,
               2'b00, 2'b00, 2'b01};
    sgn_v = '{1'b1, 1'b0, 1'b1, 1'b0,
              1'b1, 1'b0, 1'b1};
    exp_v = '{32'hFFFF_FF80, 32'h0000_0080,
              32'hFFFF_FF80, 32'h0000_FF80,
              32'hFFFF_FFFF, 32'h0000_0000,
              32'hFFFF_8001};
    poke(32'h30, 32'h0000_FF80);
    poke(32'h34, 32'h8001_7F00);
    for (int i = 0; i < 7; i++) begin
      xact(1'b0, size_v[i], sgn_v[i], addr_v[i], 32'h0,
           rd, er, lat, wr, wa);
      finish_resp();
      checks++;
      if (rd !== exp_v[i] || er !== 1'b0 || lat !== 2) begin
        failures++;
        $display("FAIL load_%0d got=%h err=%b lat=%0d exp=%h err=0 lat=2",
                 i, rd, er, lat, exp_v[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, wa;
    logic er;
    int lat, wr;
    xact(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || wr !== 0) begin
      failures++;
      $display("FAIL err_range err=%b rd=%h lat=%0d wr=%0d exp err=1 rd=0 lat=1 wr=0",
               er, rd, lat, wr);
    end
    xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      failures++;
      $display("FAIL err_size err=%b rd=%h lat=%0d exp err=1 rd=0 lat=1",
               er, rd, lat);
    end
    xact(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'h1111_1111,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (er !== 1'b1 || wr !== 0 || mem[4] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL err_store err=%b wr=%0d mem=%h exp err=1 wr=0 mem=deadbeef",
               er, wr, mem[4]);
    end
    xact(1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hA5A5_5A5A,
         rd, er, lat, wr, wa);
    finish_resp();
    xact(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0,
         rd, er, lat, wr, wa);
    finish_resp();
    checks++;
    if (er !== 1'b0 || rd !== 32'hA5A5_5A5A) begin
      failures++;
      $display("FAIL top_word err=%b rd=%h exp err=0 rd=a5a55a5a", er, rd);
    end
  endtask

  task automatic test_stall_misalign();
    logic [31:0] rd, wa;
    logic er;
    int lat, wr;
    logic [31:0] exp_rd;
    logic exp_er;
    int exp_lat;
`ifdef MISALIGN_TRAP_EN
    exp_rd = 32'h0;
    exp_er = 1'b1;
    exp_lat = 1;
`else
    exp_rd = 32'h89AB_CDEF;
    exp_er = 1'b0;
    exp_lat = 2;
`endif
    poke(32'h10, 32'h89AB_CDEF);
    xact(1'b0, 2'b10, 1'b0, 32'h12, 32'h0,
         rd, er, lat, wr, wa);
    checks++;
    if (rd !== exp_rd || er !== exp_er || lat !== exp_lat) begin
      failures++;
      $display("FAIL misalign_word rd=%h err=%b lat=%0d exp rd=%h err=%b lat=%0d",
               rd, er, lat, exp_rd, exp_er, exp_lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rd ||
          resp_err !== exp_er || req_ready !== 1'b0 ||
          mem_addr !== 32'h0) begin
        failures++;
        $display("FAIL stall_%0d v=%b rd=%h err=%b rdy=%b ma=%h exp v=1 rd=%h err=%b rdy=0 ma=0",
                 i, resp_valid, resp_rdata, resp_err, req_ready,
                 mem_addr, exp_rd, exp_er);
      end
    end
    finish_resp();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wa;
    logic er;
    int lat, wr;
    poke(32'h50, 32'hCAFE_F00D);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
         rd, er, lat, wr, wa);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = 2'b10;
    req_signed = 1'b0;
    req_addr = 32'h50;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_no_accept v=%b rdy=%b exp v=0 rdy=1",
               resp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept rdy=%b exp=0", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL b2b_data v=%b rd=%h exp v=1 rd=cafef00d",
               resp_valid, resp_rdata);
    end
    finish_resp();
  endtask

  task automatic test_mid_reset();
    poke(32'h40, 32'h5555_5555);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b10;
    req_addr = 32'h40;
    req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (mem_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_write wr_en=%b exp=1", mem_wr_en);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_drop wr_en=%b ma=%h exp wr_en=0 ma=0",
               mem_wr_en, mem_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem[16] !== 32'h5555_5555) begin
      failures++;
      $display("FAIL rst_mem got=%h exp=55555555", mem[16]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rst_idle_%0d v=%b rdy=%b exp v=0 rdy=1",
                 i, resp_valid, req_ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_subword_store();
    test_loads();
    test_errors();
    test_stall_misalign();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
